// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter family: FSM states, slave select codes
// and the location of the slave-select field inside the address.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [2:0] SLV0 = 3'd1;
  localparam logic [2:0] SLV1 = 3'd2;
  localparam logic [2:0] SLV2 = 3'd3;
  localparam logic [2:0] SLV3 = 3'd4;

  localparam int SEL_HI = 18;
  localparam int SEL_LO = 16;

  function automatic logic [1:0] master_oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bus_arb_ctrl_if.sv
// Signal bundle between the two masters, the arbiter and the slave select lines.
interface bus_arb_ctrl_if #(
  parameter int DW = 32
);
  // Handshake: a master holds req high (with stable addr/wr/wdata) until its
  // done pulse; the slave completes an access by raising s_ready while its
  // select bit is high, and s_rdata is taken in that same cycle.
  logic [1:0]    req;
  logic [31:0]   addr0;
  logic [31:0]   addr1;
  logic [1:0]    wr;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic          err;
  logic [DW-1:0] rdata;
  logic [3:0]    slave;
  logic [31:0]   s_addr;
  logic          s_wr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;
  logic          s_ready;

  modport slave_mp (
    input  req, addr0, addr1, wr, wdata0, wdata1, s_rdata, s_ready,
    output gnt, done, err, rdata, slave, s_addr, s_wr, s_wdata
  );

  modport master_mp (
    output req, addr0, addr1, wr, wdata0, wdata1, s_rdata, s_ready,
    input  gnt, done, err, rdata, slave, s_addr, s_wr, s_wdata
  );
endinterface

// File: rtl/bus_arb_ctrl_slv_dec.sv
// Address select field to one-hot slave select; codes outside SLV0..SLV3
// decode to no slave and are reported as unmapped.
module slv_dec
  import bus_pkg::*;
(
  input  logic [2:0] sel_i,
  output logic [3:0] onehot_o,
  output logic       mapped_o
);

  always_comb begin
    onehot_o = 4'b0000;
    case (sel_i)
      SLV0:    onehot_o = 4'b0001;
      SLV1:    onehot_o = 4'b0010;
      SLV2:    onehot_o = 4'b0100;
      SLV3:    onehot_o = 4'b1000;
      default: onehot_o = 4'b0000;
    endcase
    mapped_o = |onehot_o;
  end

endmodule

// File: rtl/bus_arb_ctrl.sv
// Two-master round-robin arbiter and access sequencer: grants one master,
// drives the decoded slave select, waits for s_ready or timeout, then pulses done.
module bus_arb_ctrl
  import bus_pkg::*;
#(
  parameter int DW  = 32,
  parameter int TMO = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  bus_arb_ctrl_if.slave_mp bus,
  output state_e           dbg_state_o
);

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          win_q, win_d;
  logic [3:0]    sel_q, sel_d;
  logic          err_q, err_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [31:0]   s_addr_q, s_addr_d;
  logic          s_wr_q, s_wr_d;
  logic [DW-1:0] s_wdata_q, s_wdata_d;

  logic          win_c;
  logic [31:0]   addr_c;
  logic [3:0]    dec_oh;
  logic          dec_mapped;

  // ptr_q names the master granted last; on a tie the other one wins.
  always_comb begin
    case (bus.req)
      2'b01:   win_c = 1'b0;
      2'b10:   win_c = 1'b1;
      default: win_c = ~ptr_q;
    endcase
  end

  assign addr_c = win_c ? bus.addr1 : bus.addr0;

  slv_dec u_slv_dec (
    .sel_i    (addr_c[SEL_HI:SEL_LO]),
    .onehot_o (dec_oh),
    .mapped_o (dec_mapped)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    sel_d     = sel_q;
    err_d     = err_q;
    tcnt_d    = tcnt_q;
    rdata_d   = rdata_q;
    s_addr_d  = s_addr_q;
    s_wr_d    = s_wr_q;
    s_wdata_d = s_wdata_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win_d     = win_c;
          s_addr_d  = addr_c;
          s_wr_d    = win_c ? bus.wr[1] : bus.wr[0];
          s_wdata_d = win_c ? bus.wdata1 : bus.wdata0;
          sel_d     = dec_oh;
          tcnt_d    = 8'd0;
          err_d     = ~dec_mapped;
          state_d   = dec_mapped ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        // A ready in the last allowed cycle wins over the timeout.
        if (bus.s_ready) begin
          if (!s_wr_q) rdata_d = bus.s_rdata;
          state_d = RESP;
        end else if (tcnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      RESP: begin
        ptr_d   = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b1;
      win_q     <= 1'b0;
      sel_q     <= 4'b0000;
      err_q     <= 1'b0;
      tcnt_q    <= 8'd0;
      rdata_q   <= '0;
      s_addr_q  <= 32'd0;
      s_wr_q    <= 1'b0;
      s_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
      tcnt_q    <= tcnt_d;
      rdata_q   <= rdata_d;
      s_addr_q  <= s_addr_d;
      s_wr_q    <= s_wr_d;
      s_wdata_q <= s_wdata_d;
    end
  end

  assign bus.gnt     = (state_q != IDLE) ? master_oh(win_q) : 2'b00;
  assign bus.done    = (state_q == RESP) ? master_oh(win_q) : 2'b00;
  assign bus.err     = (state_q == RESP) && err_q;
  assign bus.slave   = (state_q == ACCESS) ? sel_q : 4'b0000;
  assign bus.rdata   = rdata_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_wr    = s_wr_q;
  assign bus.s_wdata = s_wdata_q;
  assign dbg_state_o = state_q;

endmodule
